// File: rtl/reg_mem_arbiter_pkg.sv
// reg_mem_pkg: shared widths and arbiter state encoding for the reg_mem access path
package reg_mem_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_BITS  = 5;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/reg_mem_arbiter_if.sv
// reg_mem_arbiter_if: two-client request bus plus the reg_mem side of the arbiter
interface reg_mem_arbiter_if;
  import reg_mem_pkg::*;
  logic [1:0]              req;
  logic [1:0]              we;
  logic [2*ADDR_BITS-1:0]  addr;
  logic [2*DATA_WIDTH-1:0] wdata;
  logic [1:0]              ack;
  logic [2*DATA_WIDTH-1:0] rdata;
  logic [ADDR_BITS-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_wen;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  ack, rdata, mem_addr, mem_wdata, mem_wen
  );
  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output ack, rdata, mem_addr, mem_wdata, mem_wen
  );
endinterface

// File: rtl/reg_mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker, the side that did not win last gets priority
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       gnt_id
);
  always_comb begin
    valid  = |req;
    gnt_id = &req ? ~last_grant : req[1];
  end
endmodule

// File: rtl/reg_mem_arbiter.sv
// reg_mem_arbiter: round-robin arbiter and access sequencer for one single-port reg_mem
module reg_mem_arbiter
  import reg_mem_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  reg_mem_arbiter_if.slave  bus
);
  state_t                  state;
  logic                    last_grant;
  logic                    gnt_id;
  logic                    op_we;
  logic                    valid;
  logic                    pick;
  logic [1:0]              gnt_mask;
  logic [1:0]              ack;
  logic [2*DATA_WIDTH-1:0] rdata;
  logic [ADDR_BITS-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_wen;
  rr_pick2 u_pick (
    .req        (bus.req),
    .last_grant (last_grant),
    .valid      (valid),
    .gnt_id     (pick)
  );
  assign gnt_mask      = gnt_id ? 2'b10 : 2'b01;
  assign bus.ack       = ack;
  assign bus.rdata     = rdata;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_wen   = mem_wen;
  // mem_addr/mem_wdata double as the latched op address/data and hold between ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      op_we      <= 1'b0;
      ack        <= '0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wen    <= 1'b0;
    end else begin
      ack     <= '0;
      mem_wen <= 1'b0;
      case (state)
        ST_IDLE: if (valid) begin
          gnt_id    <= pick;
          op_we     <= bus.we[pick];
          mem_addr  <= bus.addr[pick*ADDR_BITS +: ADDR_BITS];
          mem_wdata <= bus.wdata[pick*DATA_WIDTH +: DATA_WIDTH];
          mem_wen   <= bus.we[pick];
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          ack   <= op_we ? gnt_mask : 2'b00;
          state <= op_we ? ST_DONE : ST_RDWAIT;
        end
        ST_RDWAIT: begin
          rdata[gnt_id*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_rdata;
          ack   <= gnt_mask;
          state <= ST_DONE;
        end
        ST_DONE: begin
          last_grant <= gnt_id;
          state      <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg_mem_arbiter.sv
// tb_reg_mem_arbiter: directed plus random checks of the arbiter against a transaction-level model
module tb_reg_mem_arbiter;
  import reg_mem_pkg::*;
  localparam int DW = DATA_WIDTH;
  localparam int AB = ADDR_BITS;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr;
  always #5 clk = ~clk;
  reg_mem_arbiter_if bus ();
  reg_mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [DW-1:0] mem [32];
  always @(posedge clk)
    if (clr) for (int i = 0; i < 32; i++) mem[i] <= '0;
    else if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr];
  int n_vec, n_err, cyc, mode, w, last, done_e, free_e;
  int grants [2];
  bit scr, act, owe;
  bit pv [2];
  bit pwe [2];
  logic [AB-1:0] pa [2];
  logic [DW-1:0] pd [2];
  logic [AB-1:0] oa, exp_ma;
  logic [DW-1:0] od, exp_md;
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] exp_rd [2];
  logic [1:0] exp_ack;
  logic exp_wen;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask
  task automatic reset_model();
    act = 0; pv[0] = 0; pv[1] = 0; last = 1; free_e = 0;
    exp_ack = '0; exp_wen = 0; exp_ma = '0; exp_md = '0;
    exp_rd[0] = '0; exp_rd[1] = '0; mode = 0; scr = 0;
  endtask
  // Transaction view: a write completes 1 edge after grant, a read 2; the next grant
  // can happen no earlier than 2 edges after completion.
  task automatic model_edge();
    exp_ack = '0;
    exp_wen = 0;
    if (act && cyc == done_e) begin
      exp_ack[w] = 1'b1;
      if (owe) ref_mem[oa] = od; else exp_rd[w] = ref_mem[oa];
      last = w; pv[w] = 0; act = 0; free_e = cyc + 2;
    end else if (!act && cyc >= free_e && (pv[0] || pv[1])) begin
      w = (pv[0] && pv[1]) ? 1 - last : (pv[1] ? 1 : 0);
      owe = pwe[w]; oa = pa[w]; od = pd[w];
      act = 1; done_e = cyc + (owe ? 1 : 2);
      exp_ma = oa; exp_md = od; exp_wen = owe;
      grants[w]++;
    end
  endtask
  task automatic drive();
    for (int p = 0; p < 2; p++) if (!pv[p]) begin
      if (mode == 1 && $urandom_range(0, 1) == 1) begin
        pv[p] = 1; pwe[p] = bit'($urandom_range(0, 1));
        pa[p] = AB'($urandom); pd[p] = DW'($urandom);
      end else if (mode == 2) begin
        pv[p] = 1; pwe[p] = 1; pa[p] = AB'(p); pd[p] = (p == 1) ? 8'h22 : 8'h11;
      end
    end
    bus.req = {pv[1], pv[0]};
    bus.we = {pwe[1], pwe[0]};
    bus.addr = {pa[1], pa[0]};
    bus.wdata = {pd[1], pd[0]};
    if (scr && act) begin
      bus.addr[w*AB +: AB] = oa + AB'(1);
      bus.wdata[w*DW +: DW] = ~od;
      bus.we[w] = ~owe;
    end
  endtask
  task automatic cycle();
    @(negedge clk);
    check("ack", 32'(bus.ack), 32'(exp_ack));
    check("mem_wen", 32'(bus.mem_wen), 32'(exp_wen));
    check("mem_addr", 32'(bus.mem_addr), 32'(exp_ma));
    check("mem_wdata", 32'(bus.mem_wdata), 32'(exp_md));
    check("rdata0", 32'(bus.rdata[0 +: DW]), 32'(exp_rd[0]));
    check("rdata1", 32'(bus.rdata[DW +: DW]), 32'(exp_rd[1]));
    drive();
    @(posedge clk);
    cyc++;
    model_edge();
  endtask
  task automatic issue(int p, bit op_we, int a, int d);
    pv[p] = 1; pwe[p] = op_we; pa[p] = AB'(a); pd[p] = DW'(d);
  endtask
  task automatic wait_idle(int lim);
    int i = 0;
    while ((act || pv[0] || pv[1]) && i < lim) begin
      cycle();
      i++;
    end
    check("drain_timeout", 32'(act || pv[0] || pv[1]), 32'h0);
    cycle();
  endtask
  task automatic hard_reset();
    rst_n = 1'b0;
    reset_model();
    bus.req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    n_vec = 0; n_err = 0; cyc = 0; grants[0] = 0; grants[1] = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    reset_model();
    clr = 1'b1;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clr = 1'b0;
    cycle();
    issue(0, 1, 5, 8'hA5);
    wait_idle(20);
    check("mem5_written", 32'(mem[5]), 32'hA5);
    issue(1, 0, 5, 0);
    wait_idle(20);
    check("read5_port1", 32'(bus.rdata[DW +: DW]), 32'hA5);
    hard_reset();
    grants[0] = 0; grants[1] = 0;
    mode = 2;
    for (int i = 0; i < 200 && (grants[0] < 4 || grants[1] < 4); i++) cycle();
    mode = 0;
    wait_idle(20);
    check("cont_mem0", 32'(mem[0]), 32'h11);
    check("cont_mem1", 32'(mem[1]), 32'h22);
    for (int i = 0; i < 32; i++) begin
      issue(0, 1, i, i);
      wait_idle(20);
    end
    for (int i = 0; i < 32; i++) begin
      issue(0, 0, i, 0);
      wait_idle(20);
      check("fill_readback", 32'(bus.rdata[0 +: DW]), 32'(i));
    end
    issue(1, 1, 3, 8'h3C);
    wait_idle(20);
    issue(1, 1, 4, 8'h4C);
    wait_idle(20);
    scr = 1;
    issue(1, 0, 3, 0);
    wait_idle(20);
    scr = 0;
    check("ignored_change", 32'(bus.rdata[DW +: DW]), 32'h3C);
    issue(0, 1, 9, 8'h77);
    for (int i = 0; i < 10 && !act; i++) cycle();
    @(negedge clk);
    check("midrst_wen_pre", 32'(bus.mem_wen), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_wen_drop", 32'(bus.mem_wen), 32'h0);
    check("midrst_ack", 32'(bus.ack), 32'h0);
    reset_model();
    bus.req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_mem9_kept", 32'(mem[9]), 32'h9);
    issue(0, 0, 9, 0);
    issue(1, 0, 0, 0);
    wait_idle(30);
    check("post_rst_rd0", 32'(bus.rdata[0 +: DW]), 32'h9);
    mode = 1;
    scr = 1;
    repeat (2000) cycle();
    mode = 0;
    wait_idle(20);
    scr = 0;
    for (int i = 0; i < 32; i++) check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
